// File: rtl/fir_ctrl_pkg.sv
// Shared state encoding and default sizes for the FIR stream sequencer.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned FIR_N       = 16;
  localparam int unsigned FIR_DEPTH   = 32;
  localparam int unsigned FIR_ADDR_W  = 5;
  localparam int unsigned FIR_LAT_DEF = 2;

endpackage

// File: rtl/fir_ctrl_tag_pipe.sv
// Valid bit plus sample index that travel in lockstep with each sample
// through the memory read, the filter input register and the filter itself.
module fir_ctrl_tag_pipe #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned IDX_W  = 5
) (
  input  logic                          clk,
  input  logic                          flush,
  input  logic                          v_in,
  input  logic [IDX_W-1:0]              idx_in,
  output logic [STAGES-1:0]             v_q,
  output logic [IDX_W-1:0]              idx_last
);

  logic [STAGES-1:0]            v_d;
  logic [STAGES-1:0][IDX_W-1:0] idx_q;
  logic [STAGES-1:0][IDX_W-1:0] idx_d;

  // Shift one stage per cycle; flush empties every stage at once.
  always_comb begin
    if (flush) begin
      v_d   = {STAGES{1'b0}};
      idx_d = {(STAGES*IDX_W){1'b0}};
    end else begin
      v_d   = {v_q[STAGES-2:0], v_in};
      idx_d = {idx_q[STAGES-2:0], idx_in};
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    v_q   <= v_d;
    idx_q <= idx_d;
  end

  assign idx_last = idx_q[STAGES-1];

endmodule

// File: rtl/fir_stream_sequencer.sv
// Plays a block of samples through an external FIR filter and writes each
// filtered output back by sample index, with a start/done handshake.
module fir_stream_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned N       = FIR_N,
  parameter int unsigned DEPTH   = FIR_DEPTH,
  parameter int unsigned ADDR_W  = FIR_ADDR_W,
  parameter int unsigned FIR_LAT = FIR_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] smp_addr,
  input  logic [N-1:0]      smp_rdata,
  output logic              fir_rst,
  output logic [N-1:0]      fir_din,
  input  logic [N-1:0]      fir_dout,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [N-1:0]      res_wdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     STAGES  = 3 + FIR_LAT;
  localparam int unsigned     CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] smp_addr_q, smp_addr_d;
  logic              fir_rst_q, fir_rst_d;
  logic [N-1:0]      fir_din_q, fir_din_d;
  logic              res_we_q, res_we_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [N-1:0]      res_wdata_q, res_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  len_c;
  logic              flush;
  logic              tag_v_in;
  logic [ADDR_W-1:0] tag_idx_in;
  logic [STAGES-1:0] tag_v;
  logic [ADDR_W-1:0] tag_idx_last;

  assign len_c = (len > DEPTH_C) ? DEPTH_C : len;
  assign flush = reset | abort;

  fir_ctrl_tag_pipe #(
    .STAGES (STAGES),
    .IDX_W  (ADDR_W)
  ) u_tag_pipe (
    .clk      (clk),
    .flush    (flush),
    .v_in     (tag_v_in),
    .idx_in   (tag_idx_in),
    .v_q      (tag_v),
    .idx_last (tag_idx_last)
  );

  // Next state, address issue and output datapath; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    smp_addr_d  = smp_addr_q;
    fir_rst_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tag_v_in    = 1'b0;
    tag_idx_in  = {ADDR_W{1'b0}};
    fir_din_d   = tag_v[1] ? smp_rdata : {N{1'b0}};
    res_we_d    = tag_v[STAGES-1];
    res_addr_d  = tag_v[STAGES-1] ? tag_idx_last : {ADDR_W{1'b0}};
    res_wdata_d = tag_v[STAGES-1] ? fir_dout : {N{1'b0}};

    if (abort) begin
      state_d     = IDLE;
      count_d     = {CNT_W{1'b0}};
      smp_addr_d  = {ADDR_W{1'b0}};
      busy_d      = 1'b0;
      fir_din_d   = {N{1'b0}};
      res_we_d    = 1'b0;
      res_addr_d  = {ADDR_W{1'b0}};
      res_wdata_d = {N{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len_c == {CNT_W{1'b0}}) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d    = FEED;
              count_d    = len_c;
              smp_addr_d = {ADDR_W{1'b0}};
              fir_rst_d  = 1'b1;
              busy_d     = 1'b1;
              tag_v_in   = 1'b1;
            end
          end else begin
            busy_d = 1'b0;
          end
        end
        FEED: begin
          if ({1'b0, smp_addr_q} == (count_q - 1'b1)) begin
            state_d = DRAIN;
          end else begin
            smp_addr_d = smp_addr_q + 1'b1;
            tag_v_in   = 1'b1;
            tag_idx_in = smp_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          // Writes are contiguous, so an empty pipe behind a write marks the last one.
          if (res_we_q && (tag_v == {STAGES{1'b0}})) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            busy_d = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= {CNT_W{1'b0}};
      smp_addr_q  <= {ADDR_W{1'b0}};
      fir_rst_q   <= 1'b0;
      fir_din_q   <= {N{1'b0}};
      res_we_q    <= 1'b0;
      res_addr_q  <= {ADDR_W{1'b0}};
      res_wdata_q <= {N{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      smp_addr_q  <= smp_addr_d;
      fir_rst_q   <= fir_rst_d;
      fir_din_q   <= fir_din_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_wdata_q <= res_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign smp_addr  = smp_addr_q;
  assign fir_rst   = fir_rst_q;
  assign fir_din   = fir_din_q;
  assign res_we    = res_we_q;
  assign res_addr  = res_addr_q;
  assign res_wdata = res_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
